// File: rtl/gen_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : gen_rr_arbiter
//  Purpose  : Round-robin scheduler sharing one write slot per cycle among N
//             requesters. The winner receives a registered one-hot grant for
//             one cycle and its data slice is written into its own lane of a
//             generated N-lane register bank at the end of that cycle.
//  Ports    : clock     - system clock, all state updates on posedge
//             reset     - asynchronous active-high reset
//             req       - [N]     level requests, held until granted
//             din       - [N*W]   write data, slice i belongs to requester i
//             gnt       - [N]     registered one-hot grant, zero when idle
//             gnt_id    - [IDW]   binary index of the grant (valid when busy)
//             busy      - high whenever gnt is non-zero
//             q         - [N*W]   lane register bank, lane i = q[i*W +: W]
//             upd       - pulses the cycle after a lane write
//             grant_cnt - [16]    saturating grant counter, present only when
//                                 GEN_RR_ARBITER_GRANT_CNT_EN is defined
//  Options  : GEN_RR_ARBITER_GRANT_CNT_EN adds the grant_cnt output.
//  Revision : 1.0 - initial release
// ============================================================================
module gen_rr_arbiter #(
    parameter  int N   = 2,
    parameter  int W   = 1,
    localparam int IDW = $clog2(N)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N-1:0]       req,
    input  logic [N*W-1:0]     din,
    output logic [N-1:0]       gnt,
    output logic [IDW-1:0]     gnt_id,
    output logic               busy,
    output logic [N*W-1:0]     q,
    output logic               upd
`ifdef GEN_RR_ARBITER_GRANT_CNT_EN
    ,
    output logic [15:0]        grant_cnt
`endif
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IDW-1:0]   gnt_id_q, gnt_id_d;
    logic [IDW-1:0]   last_q, last_d;
    logic             upd_q, upd_d;

    // Rotating search result
    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [IDW-1:0]   cand;

    // ------------------------------------------------------------------------
    // Rotating priority search: examine last+1, last+2, ... modulo N. The
    // previous winner is visited last, so a request it still holds during its
    // own grant cycle only wins when nobody else is asking.
    // ------------------------------------------------------------------------
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int off = 1; off <= N; off++) begin
            cand = IDW'((int'(last_q) + off) % N);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. Arbitration is the same in IDLE and GRANT, which is
    // what allows back-to-back grants with no idle bubble.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = S_IDLE;
        gnt_d    = '0;
        gnt_id_d = gnt_id_q;
        last_d   = last_q;
        upd_d    = (state_q == S_GRANT);

        if (win_found) begin
            state_d  = S_GRANT;
            gnt_d    = N'(1) << win_idx;
            gnt_id_d = win_idx;
            last_d   = win_idx;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            last_q   <= IDW'(N - 1);
            upd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            last_q   <= last_d;
            upd_q    <= upd_d;
        end
    end

    // ------------------------------------------------------------------------
    // Lane register bank: each lane only captures its own slice, and only at
    // the closing edge of its own grant cycle.
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [W-1:0] lane_q;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                lane_q <= '0;
            end else if ((state_q == S_GRANT) && gnt_q[i]) begin
                lane_q <= din[i*W +: W];
            end
        end

        assign q[i*W +: W] = lane_q;
    end

`ifdef GEN_RR_ARBITER_GRANT_CNT_EN
    logic [15:0] grant_cnt_q;

    // Counts closing edges of grant cycles, holding at the maximum value
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_cnt_q <= '0;
        end else if ((state_q == S_GRANT) && (grant_cnt_q != 16'hFFFF)) begin
            grant_cnt_q <= grant_cnt_q + 16'd1;
        end
    end

    assign grant_cnt = grant_cnt_q;
`endif

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = |gnt_q;
    assign upd    = upd_q;

endmodule
`default_nettype wire

// File: tb/tb_gen_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gen_rr_arbiter
//  Purpose  : Self-checking bench for gen_rr_arbiter. A 2-lane x 1-bit
//             instance is driven from a vector table and short hand-written
//             sequences; a 4-lane x 4-bit instance is driven with random
//             requests and compared against an integer reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gen_rr_arbiter;

    logic clk;
    logic rst;

    // 2 x 1 instance
    logic [1:0]  req2, din2, gnt2, q2;
    logic [0:0]  id2;
    logic        busy2, upd2;
    // 4 x 4 instance
    logic [3:0]  req4, gnt4;
    logic [15:0] din4, q4;
    logic [1:0]  id4;
    logic        busy4, upd4;
`ifdef GEN_RR_ARBITER_GRANT_CNT_EN
    logic [15:0] cnt2, cnt4;
`endif

    int n_vec;
    int n_err;

    gen_rr_arbiter #(.N(2), .W(1)) u_dut2 (
        .clock (clk), .reset (rst), .req (req2), .din (din2),
        .gnt (gnt2), .gnt_id (id2), .busy (busy2), .q (q2), .upd (upd2)
`ifdef GEN_RR_ARBITER_GRANT_CNT_EN
        , .grant_cnt (cnt2)
`endif
    );

    gen_rr_arbiter #(.N(4), .W(4)) u_dut4 (
        .clock (clk), .reset (rst), .req (req4), .din (din4),
        .gnt (gnt4), .gnt_id (id4), .busy (busy4), .q (q4), .upd (upd4)
`ifdef GEN_RR_ARBITER_GRANT_CNT_EN
        , .grant_cnt (cnt4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    // ---------------- table-driven vectors for the 2 x 1 instance ----------
    typedef struct {
        logic [1:0] req;
        logic [1:0] din;
        logic [1:0] gnt;
        logic       id;
        logic [1:0] q;
        logic       upd;
    } vec_t;

    vec_t tbl[13];

    // ---------------- reference model for the 4 x 4 instance ---------------
    int         m_last;
    int         m_gnt;      // -1 when no grant is active
    logic [3:0] m_lane[4];
    logic       m_upd;

    task automatic model_reset();
        m_last = 3;
        m_gnt  = -1;
        m_upd  = 1'b0;
        for (int i = 0; i < 4; i++) m_lane[i] = 4'h0;
    endtask

    // One clock edge of the specified behaviour, given inputs seen at the edge
    task automatic model_edge(input logic [3:0] r, input logic [15:0] d);
        int nxt;
        m_upd = (m_gnt >= 0);
        if (m_gnt >= 0) m_lane[m_gnt] = d[m_gnt*4 +: 4];
        nxt = -1;
        for (int off = 1; off <= 4; off++) begin
            if (nxt < 0 && r[(m_last + off) % 4]) nxt = (m_last + off) % 4;
        end
        m_gnt = nxt;
        if (nxt >= 0) m_last = nxt;
    endtask

    task automatic model_check();
        logic [15:0] eq;
        logic [3:0]  eg;
        eq = {m_lane[3], m_lane[2], m_lane[1], m_lane[0]};
        eg = (m_gnt >= 0) ? (4'b0001 << m_gnt) : 4'b0000;
        chk("rnd_gnt",  32'(gnt4),  32'(eg));
        chk("rnd_busy", 32'(busy4), 32'(m_gnt >= 0));
        chk("rnd_q",    32'(q4),    32'(eq));
        chk("rnd_upd",  32'(upd4),  32'(m_upd));
        if (m_gnt >= 0) chk("rnd_id", 32'(id4), 32'(m_gnt));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        req2  = '0; din2 = '0;
        req4  = '0; din4 = '0;

        tbl[0]  = '{2'b01, 2'b01, 2'b01, 1'b0, 2'b00, 1'b0};
        tbl[1]  = '{2'b01, 2'b01, 2'b01, 1'b0, 2'b01, 1'b1};
        tbl[2]  = '{2'b00, 2'b01, 2'b00, 1'b0, 2'b01, 1'b1};
        tbl[3]  = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0};
        tbl[4]  = '{2'b11, 2'b10, 2'b10, 1'b1, 2'b01, 1'b0};
        tbl[5]  = '{2'b11, 2'b10, 2'b01, 1'b0, 2'b11, 1'b1};
        tbl[6]  = '{2'b11, 2'b10, 2'b10, 1'b1, 2'b10, 1'b1};
        tbl[7]  = '{2'b11, 2'b10, 2'b01, 1'b0, 2'b10, 1'b1};
        tbl[8]  = '{2'b00, 2'b10, 2'b00, 1'b0, 2'b10, 1'b1};
        tbl[9]  = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b10, 1'b0};
        tbl[10] = '{2'b10, 2'b11, 2'b10, 1'b1, 2'b10, 1'b0};
        tbl[11] = '{2'b00, 2'b01, 2'b00, 1'b0, 2'b00, 1'b1};
        tbl[12] = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0};

        // Reset held 3 cycles, then 10 idle cycles
        repeat (3) tick();
        chk("rst_gnt", 32'(gnt2), 32'h0);
        chk("rst_q",   32'(q2),   32'h0);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_gnt",  32'(gnt2),  32'h0);
            chk("idle_busy", 32'(busy2), 32'h0);
            chk("idle_q",    32'(q2),    32'h0);
            chk("idle_upd",  32'(upd2),  32'h0);
        end

        // Single requester, two competitors, and withdrawal during grant
        for (int v = 0; v < 13; v++) begin
            req2 = tbl[v].req;
            din2 = tbl[v].din;
            tick();
            chk($sformatf("tbl%0d_gnt", v),  32'(gnt2),  32'(tbl[v].gnt));
            chk($sformatf("tbl%0d_busy", v), 32'(busy2), 32'(|tbl[v].gnt));
            chk($sformatf("tbl%0d_q", v),    32'(q2),    32'(tbl[v].q));
            chk($sformatf("tbl%0d_upd", v),  32'(upd2),  32'(tbl[v].upd));
            if (|tbl[v].gnt) chk($sformatf("tbl%0d_id", v), 32'(id2), 32'(tbl[v].id));
        end

        // Sparse requests on 4 lanes with wrap-around
        req4 = '0; din4 = '0;
        do_reset(2);
        req4 = 4'b1010;
        din4 = 16'hAAAA;
        tick();
        chk("w4_g1", 32'(gnt4), 32'b0010);
        chk("w4_i1", 32'(id4),  32'd1);
        tick();
        chk("w4_g2", 32'(gnt4), 32'b1000);
        chk("w4_q2", 32'(q4),   32'h00A0);
        chk("w4_u2", 32'(upd4), 32'd1);
        tick();
        chk("w4_g3", 32'(gnt4), 32'b0010);
        chk("w4_q3", 32'(q4),   32'hA0A0);
        req4 = 4'b0000;
        tick();
        tick();
        chk("w4_qf", 32'(q4),   32'hA0A0);
        chk("w4_gf", 32'(gnt4), 32'h0);

        // Asynchronous reset in the middle of a lane 0 grant
        req2 = '0; din2 = '0;
        do_reset(2);
        req2 = 2'b11;
        din2 = 2'b11;
        tick();
        tick();
        tick();
        chk("ar_pre_gnt", 32'(gnt2), 32'b01);
        chk("ar_pre_q",   32'(q2),   32'b11);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_gnt",  32'(gnt2),  32'h0);
        chk("ar_busy", 32'(busy2), 32'h0);
        chk("ar_q",    32'(q2),    32'h0);
        chk("ar_upd",  32'(upd2),  32'h0);
        tick();
        #2;
        rst = 1'b0;
        tick();
        chk("ar_first_gnt", 32'(gnt2), 32'b01);
        chk("ar_first_upd", 32'(upd2), 32'h0);

        // Random requests on the 4 x 4 instance against the model
        req4 = '0; din4 = '0;
        do_reset(2);
        model_reset();
        model_check();
        for (int c = 0; c < 400; c++) begin
            req4 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req4 = 4'b0000;
            din4 = 16'($urandom);
            model_edge(req4, din4);
            tick();
            model_check();
        end

`ifdef GEN_RR_ARBITER_GRANT_CNT_EN
        req2 = '0; din2 = '0;
        do_reset(2);
        chk("cnt_rst", 32'(cnt2), 32'h0);
        req2 = 2'b11;
        repeat (10) tick();
        chk("cnt_10", 32'(cnt2), 32'd9);
        repeat (69990) tick();
        chk("cnt_sat", 32'(cnt2), 32'hFFFF);
        repeat (5) tick();
        chk("cnt_hold", 32'(cnt2), 32'hFFFF);
        req2 = '0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
